// File: rtl/muldiv_engine.sv
// muldiv_engine: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Define MDU_MADD_EN to enable the MADD/MSUB accumulate ops (9/10); otherwise they decode as NOP.
module muldiv_engine #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
`endif

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic             state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_commit;

    logic [2*WIDTH-1:0] a_sx;
    logic [2*WIDTH-1:0] b_sx;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;

    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] divisor_s;
    logic [WIDTH-1:0] divisor_u;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] q_u;
    logic [WIDTH-1:0] r_u;

    logic             is_md;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [CNT_W-1:0] load_cnt;
    logic             res_commit;

    // Sign-extending to 2*WIDTH lets a plain truncated multiply yield the signed product.
    assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign a_neg  = a[WIDTH-1];
    assign b_neg  = b[WIDTH-1];
    assign b_zero = (b == '0);
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    // A zero divisor is swapped for 1 so the dividers never see it; the result is discarded anyway.
    assign divisor_s = b_zero ? WIDTH'(1) : b_mag;
    assign divisor_u = b_zero ? WIDTH'(1) : b;
    assign q_mag     = a_mag / divisor_s;
    assign r_mag     = a_mag % divisor_s;
    assign q_s       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign r_s       = a_neg ? -r_mag : r_mag;
    assign q_u       = a / divisor_u;
    assign r_u       = a % divisor_u;

    always_comb begin
        is_md      = 1'b1;
        res_hi     = '0;
        res_lo     = '0;
        load_cnt   = MUL_CNT;
        res_commit = 1'b1;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_hi     = r_s;
                res_lo     = q_s;
                load_cnt   = DIV_CNT;
                res_commit = !b_zero;
            end
            OP_DIVU: begin
                res_hi     = r_u;
                res_lo     = q_u;
                load_cnt   = DIV_CNT;
                res_commit = !b_zero;
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            OP_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
`endif
            default:  is_md = 1'b0;
        endcase
    end

    // Result is computed at start and held in pending regs; the countdown only models latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            pend_hi     <= '0;
            pend_lo     <= '0;
            pend_commit <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_md) begin
                            state       <= S_RUN;
                            cnt         <= load_cnt;
                            pend_hi     <= res_hi;
                            pend_lo     <= res_lo;
                            pend_commit <= res_commit;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        if (pend_commit) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign out  = (op == OP_MFHI) ? hi : (op == OP_MFLO) ? lo : '0;

endmodule
